sdram_bank: RTL
===============

# sdram_bank

Parametrised single-bank SDRAM model with a row buffer, programmable burst length and CAS latency, auto-refresh tracking and illegal-command flagging. It sits between the memory controller and the rest of the design as the storage end of the memory subsystem. It replaces the fixed 16x16x8 single-burst model with a configurable bank that has asynchronous reset, split data buses, a registered read pipeline and explicit precharge write-back.

## Interface
- DATA_WIDTH, 8, bits per column word
- ADDR_BITS, 4, row and column address width; bank is 2^ADDR_BITS rows x 2^ADDR_BITS columns
- BURST_LENGTH, 4, words per READ/WRITE burst, 1..2^ADDR_BITS
- CAS_LATENCY, 2, READ-to-first-data delay in cycles, >=1
- REFRESH_INTERVAL, 64, cycles after which refresh_due asserts, >=1
- clock  input  1  single clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high
- chip_enable_not  input  1  low = command bus valid
- ras_not, cas_not, write_not  input  1 each  command encoding
- partial_address_bus  input  ADDR_BITS  row (ACTIVATE) or start column (READ/WRITE)
- data_in  input  DATA_WIDTH  write data
- data_out  output  DATA_WIDTH  read data, 0 when data_out_valid low
- data_out_valid  output  1  read beat present
- busy  output  1  high in READ, WRITE, REFRESH states
- refresh_due  output  1  refresh interval elapsed
- cmd_error  output  1  one-cycle pulse for an illegal or ill-timed command

## Operation
- Command decoded only when chip_enable_not=0; {ras_not,cas_not,write_not}: 011 ACTIVATE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 REFRESH, 11x NOP; chip_enable_not=1 is NOP.
- States: IDLE, ACTIVE, READ, WRITE, REFRESH.
- IDLE: ACTIVATE copies memory[addr] into row buffer, records open row -> ACTIVE. REFRESH -> REFRESH.
- ACTIVE: READ/WRITE latch start column -> READ/WRITE. PRECHARGE writes row buffer back to memory[open row] -> IDLE. ACTIVATE is illegal here; there is no implicit precharge.
- READ/WRITE: column increments by 1 per beat, wrapping modulo 2^ADDR_BITS. After BURST_LENGTH beats -> ACTIVE.
- Reads and writes operate on the row buffer only. Reads after writes in the same open row return the new data. Memory is updated only at PRECHARGE.
- REFRESH: rewrites memory[refresh_row] unchanged, increments refresh_row (wraps at 2^ADDR_BITS), clears the interval counter -> IDLE.
- Any command not listed as legal for the current state (including any non-NOP in READ/WRITE/REFRESH) is ignored, and cmd_error pulses. State and data are unaffected.
- Interval counter increments every cycle and saturates at REFRESH_INTERVAL. refresh_due = (counter == REFRESH_INTERVAL). It is not auto-serviced.
- Reset: state IDLE, data_out=0, data_out_valid=0, busy=0, refresh_due=0, cmd_error=0, refresh_row=0, counter=0, read pipeline flushed. Memory contents are not cleared.
- Reset during WRITE: the row buffer is discarded and memory is unchanged. Reset during READ: pending beats are dropped.

## Timing
- ACTIVATE at edge n: READ/WRITE legal from edge n+1.
- WRITE at edge n, column c: data_in sampled at edges n..n+BURST_LENGTH-1 into columns c..c+BURST_LENGTH-1. State WRITE between these edges, and ACTIVE from edge n+BURST_LENGTH.
- READ at edge n, column c: beat k (column c+k) registered onto data_out with data_out_valid=1 at edge n+CAS_LATENCY-1+k, for k=0..BURST_LENGTH-1. State ACTIVE from edge n+BURST_LENGTH. Trailing pipeline beats still emerge after PRECHARGE or a new READ; back-to-back READ at edge n+BURST_LENGTH gives gapless data.
- PRECHARGE at edge n: write-back at edge n, IDLE from n+1, ACTIVATE legal at edge n+1.
- REFRESH at edge n: busy=1 after edge n, IDLE after edge n+1, refresh_due low after edge n.
- cmd_error high for exactly the cycle after the offending edge.
- BURST_LENGTH=1 degenerates to a single beat. The state returns to ACTIVE on the next edge and busy never rises for WRITE.

## Test plan
- Defaults: reset, ACTIVATE row 3, WRITE col 2 with data 0xA1,0xA2,0xA3,0xA4, PRECHARGE, ACTIVATE 3, READ col 2 -> data_out_valid on edges n+1..n+4 carrying 0xA1..0xA4.
- Wrap: WRITE col 14 with 0x10..0x13 then READ col 14 -> columns 14,15,0,1 return 0x10,0x11,0x12,0x13.
- Buffer-only write: WRITE row 5 col 0 with 0x55s, no PRECHARGE, assert reset, ACTIVATE 5, READ -> original contents returned.
- Illegal commands: READ in IDLE, ACTIVATE in ACTIVE, WRITE mid-burst -> cmd_error one-cycle pulse each, state and data unchanged.
- Refresh: idle 64 cycles -> refresh_due=1 from cycle 64; REFRESH -> busy for 1 cycle, refresh_due=0, refresh_row 0->1; 16 refreshes wrap refresh_row to 0.
- Parameter sweep DATA_WIDTH=16, ADDR_BITS=6, BURST_LENGTH=8, CAS_LATENCY=3: 8-beat write/read matches, first beat at edge n+2.

Source files
------------

// File: rtl/sdram_bank.sv
// rtl/sdram_bank.sv - single-bank SDRAM model with row buffer, burst read/write and refresh tracking
// Reads and writes touch only the row buffer; the array is updated on PRECHARGE write-back.
module sdram_bank #(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_BITS        = 4,
  parameter int BURST_LENGTH     = 4,
  parameter int CAS_LATENCY      = 2,
  parameter int REFRESH_INTERVAL = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  chip_enable_not,
  input  logic                  ras_not,
  input  logic                  cas_not,
  input  logic                  write_not,
  input  logic [ADDR_BITS-1:0]  partial_address_bus,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  busy,
  output logic                  refresh_due,
  output logic                  cmd_error
);
  localparam int COLS   = 1 << ADDR_BITS;
  localparam int BEAT_W = $clog2(BURST_LENGTH + 1);
  localparam int CNT_W  = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [BEAT_W-1:0] BURST_LAST = BEAT_W'(BURST_LENGTH - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(1);
  localparam logic [CNT_W-1:0]  INTERVAL   = CNT_W'(REFRESH_INTERVAL);
  localparam logic [CNT_W-1:0]  INTERVAL_M1 = CNT_W'(REFRESH_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_READ,
    S_WRITE,
    S_REFRESH
  } state_t;

  state_t                state;
  logic [ADDR_BITS-1:0]  open_row;
  logic [ADDR_BITS-1:0]  column;
  logic [ADDR_BITS-1:0]  refresh_row;
  logic [BEAT_W-1:0]     beats_left;
  logic [CNT_W-1:0]      interval_count;

  logic [DATA_WIDTH-1:0] memory     [COLS][COLS];
  logic [DATA_WIDTH-1:0] row_buffer [COLS];
  logic [DATA_WIDTH-1:0] pipe_data  [CAS_LATENCY];
  logic                  pipe_valid [CAS_LATENCY];

  logic [2:0]            cmd_code;
  logic                  cmd_present;
  logic                  cmd_activate;
  logic                  cmd_read;
  logic                  cmd_write;
  logic                  cmd_precharge;
  logic                  cmd_refresh;
  logic                  idle_cmd_ok;
  logic                  active_cmd_ok;
  logic                  cmd_illegal;
  logic                  read_beat;
  logic                  write_beat;
  logic [ADDR_BITS-1:0]  beat_column;

  // 11x on {ras,cas,we} is a NOP even with the chip selected
  always_comb begin
    cmd_code      = {ras_not, cas_not, write_not};
    cmd_present   = !chip_enable_not && (cmd_code[2:1] != 2'b11);
    cmd_activate  = cmd_present && (cmd_code == 3'b011);
    cmd_read      = cmd_present && (cmd_code == 3'b101);
    cmd_write     = cmd_present && (cmd_code == 3'b100);
    cmd_precharge = cmd_present && (cmd_code == 3'b010);
    cmd_refresh   = cmd_present && (cmd_code == 3'b001);
    idle_cmd_ok   = (state == S_IDLE) && (cmd_activate || cmd_refresh);
    active_cmd_ok = (state == S_ACTIVE) && (cmd_read || cmd_write || cmd_precharge);
    cmd_illegal   = cmd_present && !idle_cmd_ok && !active_cmd_ok;
    read_beat     = (state == S_READ) || ((state == S_ACTIVE) && cmd_read);
    write_beat    = (state == S_WRITE) || ((state == S_ACTIVE) && cmd_write);
    beat_column   = (state == S_ACTIVE) ? partial_address_bus : column;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      open_row       <= '0;
      column         <= '0;
      refresh_row    <= '0;
      beats_left     <= '0;
      interval_count <= '0;
      busy           <= 1'b0;
      refresh_due    <= 1'b0;
      cmd_error      <= 1'b0;
    end else begin
      cmd_error <= cmd_illegal;
      case (state)
        S_IDLE: begin
          if (cmd_activate) begin
            open_row <= partial_address_bus;
            state    <= S_ACTIVE;
          end else if (cmd_refresh) begin
            // The refreshed row's contents are kept as-is; only the pointer moves.
            refresh_row <= refresh_row + 1'b1;
            state       <= S_REFRESH;
            busy        <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (cmd_read || cmd_write) begin
            column     <= partial_address_bus + 1'b1;
            beats_left <= BURST_LAST;
            if (BURST_LENGTH > 1) begin
              state <= cmd_read ? S_READ : S_WRITE;
              busy  <= 1'b1;
            end
          end else if (cmd_precharge) begin
            state <= S_IDLE;
          end
        end
        S_READ, S_WRITE: begin
          column     <= column + 1'b1;
          beats_left <= beats_left - 1'b1;
          if (beats_left == LAST_BEAT) begin
            state <= S_ACTIVE;
            busy  <= 1'b0;
          end
        end
        S_REFRESH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (idle_cmd_ok && cmd_refresh) begin
        interval_count <= '0;
        refresh_due    <= 1'b0;
      end else if (interval_count != INTERVAL) begin
        interval_count <= interval_count + 1'b1;
        refresh_due    <= (interval_count == INTERVAL_M1);
      end
    end
  end

  // Beat k enters stage 0 on its burst edge and reaches data_out CAS_LATENCY-1 edges later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CAS_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_data[i]  <= '0;
      end
    end else begin
      pipe_valid[0] <= read_beat;
      pipe_data[0]  <= read_beat ? row_buffer[beat_column] : '0;
      for (int i = 1; i < CAS_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign data_out       = pipe_data[CAS_LATENCY-1];
  assign data_out_valid = pipe_valid[CAS_LATENCY-1];

  // Storage is not reset; a reset simply abandons whatever the row buffer held.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (idle_cmd_ok && cmd_activate) begin
        for (int c = 0; c < COLS; c++) begin
          row_buffer[c] <= memory[partial_address_bus][c];
        end
      end else if (write_beat) begin
        row_buffer[beat_column] <= data_in;
      end
      if (active_cmd_ok && cmd_precharge) begin
        for (int c = 0; c < COLS; c++) begin
          memory[open_row][c] <= row_buffer[c];
        end
      end
    end
  end

endmodule
